// File: rtl/cache_mem_pkg.sv
// cache_mem_pkg: shared FSM encoding and line geometry for cache_mem_responder
package cache_mem_pkg;
  typedef enum logic [1:0] {IDLE, LATENCY, BURST, DONE} resp_state_e;
  localparam int BEATS = 4;
  localparam int LAT_CNT_WIDTH = 4;
endpackage

// File: rtl/cache_mem_array.sv
// cache_mem_array: single-port word RAM, synchronous write, combinational read.
module cache_mem_array #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: memory-side line-fill/write-back burst responder for the d_cache interface.
// Define MEM_RESP_STALL_EN to insert one bubble cycle between consecutive beats.
module cache_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDRESS_WIDTH      = 22,
  parameter int BLOCK_OFFSET_WIDTH = $clog2(BEATS),
  parameter int MEM_WORDS_WIDTH    = 10,
  parameter int ACCESS_LATENCY     = 4
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic                     i_MEM_Valid,
  input  logic                     i_MEM_Read_Write_n,
  input  logic [ADDRESS_WIDTH-1:0] i_MEM_Address,
  input  logic [DATA_WIDTH-1:0]    i_MEM_Data,
  output logic                     o_MEM_Valid,
  output logic                     o_MEM_Data_Read,
  output logic                     o_MEM_Last,
  output logic [DATA_WIDTH-1:0]    o_MEM_Data
);
  localparam int LW = MEM_WORDS_WIDTH - BLOCK_OFFSET_WIDTH;
`ifdef MEM_RESP_STALL_EN
  localparam logic STALL = 1'b1;
`else
  localparam logic STALL = 1'b0;
`endif
  resp_state_e state_q, state_d;
  logic [LAT_CNT_WIDTH-1:0] lat_q, lat_d;
  logic [BLOCK_OFFSET_WIDTH-1:0] beat_q, beat_d, nxt;
  logic [LW-1:0] line_q, line_d;
  logic rd_q, rd_d, bub_q, bub_d, present, we;
  logic [DATA_WIDTH-1:0] rdata;
  logic [MEM_WORDS_WIDTH-1:0] addr;
  logic addr_unused;
  assign addr_unused = &{i_MEM_Address[ADDRESS_WIDTH-1:MEM_WORDS_WIDTH+1], i_MEM_Address[BLOCK_OFFSET_WIDTH:0]};
  // read bursts look one beat ahead so the registered data lines up with its strobe
  assign nxt = (state_q == LATENCY) ? '0 : beat_q + 1'b1;
  assign addr = {line_q, rd_q ? nxt : beat_q};
  assign we = o_MEM_Data_Read & i_MEM_Valid;
  cache_mem_array #(.DW(DATA_WIDTH), .AW(MEM_WORDS_WIDTH)) u_array (
    .clk(i_Clk), .we(we), .addr(addr), .wdata(i_MEM_Data), .rdata(rdata)
  );
  always_comb begin
    state_d = state_q;
    lat_d = lat_q;
    beat_d = beat_q;
    line_d = line_q;
    rd_d = rd_q;
    bub_d = 1'b0;
    present = 1'b0;
    case (state_q)
      IDLE: if (i_MEM_Valid) begin
        state_d = LATENCY;
        line_d = i_MEM_Address[MEM_WORDS_WIDTH:BLOCK_OFFSET_WIDTH+1];
        rd_d = i_MEM_Read_Write_n;
        lat_d = LAT_CNT_WIDTH'(ACCESS_LATENCY - 1);
      end
      LATENCY: if (!i_MEM_Valid) state_d = IDLE;
        else if (lat_q == '0) begin
          state_d = BURST;
          beat_d = '0;
          present = 1'b1;
        end else lat_d = lat_q - 1'b1;
      BURST: if (!i_MEM_Valid) state_d = IDLE;
        else if (!bub_q && beat_q == '1) state_d = DONE;
        else if (STALL && !bub_q) bub_d = 1'b1;
        else begin
          beat_d = nxt;
          present = 1'b1;
        end
      default: if (!i_MEM_Valid) state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_Clk or negedge i_Reset_n)
    if (!i_Reset_n) begin
      state_q <= IDLE;
      lat_q <= '0;
      beat_q <= '0;
      line_q <= '0;
      rd_q <= 1'b0;
      bub_q <= 1'b0;
      o_MEM_Valid <= 1'b0;
      o_MEM_Data_Read <= 1'b0;
      o_MEM_Last <= 1'b0;
      o_MEM_Data <= '0;
    end else begin
      state_q <= state_d;
      lat_q <= lat_d;
      beat_q <= beat_d;
      line_q <= line_d;
      rd_q <= rd_d;
      bub_q <= bub_d;
      o_MEM_Valid <= present & rd_q;
      o_MEM_Data_Read <= present & ~rd_q;
      o_MEM_Last <= present & (nxt == '1);
      o_MEM_Data <= (present & rd_q) ? rdata : '0;
    end
endmodule

// File: tb/tb_cache_mem_responder.sv
// tb_cache_mem_responder: directed bench with a read-beat scoreboard and a word model of memory.
// Build with MEM_RESP_STALL_EN to check the bubbled beat timing.
module tb_cache_mem_responder;
  logic clk = 1'b0, rst_n = 1'b0, v = 1'b0, rw = 1'b0;
  logic [21:0] a = '0;
  logic [31:0] wd = '0;
  logic ov, odr, ol;
  logic [31:0] od;
  always #5 clk = ~clk;
  cache_mem_responder dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_MEM_Valid(v), .i_MEM_Read_Write_n(rw),
    .i_MEM_Address(a), .i_MEM_Data(wd), .o_MEM_Valid(ov), .o_MEM_Data_Read(odr),
    .o_MEM_Last(ol), .o_MEM_Data(od)
  );
`ifdef MEM_RESP_STALL_EN
  localparam logic [31:0] VP = 32'h0000_0AA0, LP = 32'h0000_0800;
`else
  localparam logic [31:0] VP = 32'h0000_01E0, LP = 32'h0000_0100;
`endif
  typedef struct packed {logic [31:0] d; logic l;} beat_t;
  beat_t sb[$];
  logic [31:0] mdl [1024];
  logic [31:0] wdat [4];
  logic [31:0] vpat, dpat, lpat;
  logic [7:0] wbase = '0;
  int widx = 0, checks = 0, errors = 0, cnt, found;
  bit pdr = 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // one cycle: commit the write beat consumed at the last edge, then sample outputs
  task automatic tick(input int t);
    logic vv;
    beat_t e;
    vv = v;
    @(negedge clk);
    if (pdr && vv) begin
      mdl[{wbase, widx[1:0]}] = wd;
      widx++;
      wd = wdat[widx[1:0]];
    end
    pdr = odr;
    if (t > 0 && t < 32) begin
      vpat[t] = ov;
      dpat[t] = odr;
      lpat[t] = ol;
    end
    if (ov) begin
      if (sb.size() == 0) chk("extra_beat", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("rdata", od, e.d);
        chk("rlast", {31'b0, ol}, {31'b0, e.l});
      end
    end
  endtask
  task automatic burst(input bit r, input logic [21:0] addr, input int n, input logic [31:0] d0);
    logic [7:0] line;
    line = addr[10:3];
    vpat = '0;
    dpat = '0;
    lpat = '0;
    if (r) for (int i = 0; i < 4; i++) sb.push_back(beat_t'{d: mdl[{line, 2'(i)}], l: (i == 3)});
    else begin
      for (int i = 0; i < 4; i++) wdat[i] = d0 + 32'(i);
      widx = 0;
      wd = d0;
      wbase = line;
      pdr = 1'b0;
    end
    v = 1'b1;
    rw = r;
    a = addr;
    for (int t = 1; t <= n; t++) begin
      tick(t);
      if (t == 2 || t == 6) begin
        rw = ~rw;
        a = ~a;
      end
    end
    v = 1'b0;
    tick(0);
    chk("valid_pattern", vpat, r ? VP : 32'h0);
    chk("dread_pattern", dpat, r ? 32'h0 : VP);
    chk("last_pattern", lpat, LP);
    chk("sb_drain", sb.size(), 32'd0);
  endtask
  initial begin
    tick(0);
    tick(0);
    chk("rst_valid", {31'b0, ov}, 32'd0);
    chk("rst_dread", {31'b0, odr}, 32'd0);
    chk("rst_last", {31'b0, ol}, 32'd0);
    chk("rst_data", od, 32'd0);
    rst_n = 1'b1;
    tick(0);
    burst(0, 22'h080, 12, 32'h0000_00A0);
    burst(1, 22'h080, 12, 32'h0);
    burst(0, 22'h100, 12, 32'h0000_00B0);
    burst(1, 22'h100, 12, 32'h0);
    burst(1, 22'h086, 12, 32'h0);
    burst(1, 22'h1080, 12, 32'h0);
    burst(1, 22'h100, 20, 32'h0);
    burst(1, 22'h100, 12, 32'h0);
    burst(0, 22'h200, 12, 32'h0000_00D0);
    // partial write: drop valid once two beats have been consumed
    for (int i = 0; i < 4; i++) wdat[i] = 32'h0000_00C0 + 32'(i);
    widx = 0;
    wd = wdat[0];
    wbase = 8'h40;
    pdr = 1'b0;
    v = 1'b1;
    rw = 1'b0;
    a = 22'h200;
    cnt = 0;
    for (int t = 1; t <= 30 && cnt < 2; t++) begin
      tick(t);
      cnt += int'(odr);
    end
    chk("abort_two_beats", cnt, 32'd2);
    tick(0);
    v = 1'b0;
    tick(0);
    chk("abort_quiet", {29'b0, ov, odr, ol}, 32'd0);
    tick(0);
    chk("abort_quiet2", {29'b0, ov, odr, ol}, 32'd0);
    burst(1, 22'h200, 12, 32'h0);
    // reset while the first read beat is on the bus
    for (int i = 0; i < 4; i++) sb.push_back(beat_t'{d: mdl[{8'h10, 2'(i)}], l: (i == 3)});
    v = 1'b1;
    rw = 1'b1;
    a = 22'h080;
    found = 0;
    for (int t = 1; t <= 20 && found == 0; t++) begin
      tick(t);
      found = int'(ov);
    end
    chk("rst_burst_seen", found, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, ov}, 32'd0);
    chk("midrst_last", {31'b0, ol}, 32'd0);
    chk("midrst_data", od, 32'd0);
    sb.delete();
    v = 1'b0;
    pdr = 1'b0;
    tick(0);
    rst_n = 1'b1;
    tick(0);
    burst(1, 22'h080, 12, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
